// File: rtl/dds_pkg.sv
// dds_pkg: shared word width, key FSM states and default tuning constants for the DDS front end
package dds_pkg;

    localparam int WORD_W      = 30;
    localparam int FC_MIN_DEF  = 21475;
    localparam int FC_STEP_DEF = 21475;
    localparam int FC_MAX_DEF  = 214750;
    localparam int PC_STEP_DEF = 268435456;

    typedef enum logic [2:0] {
        KEY_IDLE       = 3'd0,
        KEY_PRESS_DB   = 3'd1,
        KEY_HELD       = 3'd2,
        KEY_REPEAT     = 3'd3,
        KEY_RELEASE_DB = 3'd4
    } key_state_e;

endpackage

// File: rtl/key_repeat.sv
// key_repeat: synchronise, debounce and auto-repeat one active-low key into one-cycle event pulses
module key_repeat
    import dds_pkg::*;
#(
    parameter int DEB_CYC  = 1_000_000,
    parameter int HOLD_CYC = 25_000_000,
    parameter int REP_CYC  = 5_000_000
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic key_n,
    output logic evt
);

    localparam int MAX_CYC = (DEB_CYC > HOLD_CYC) ? ((DEB_CYC > REP_CYC) ? DEB_CYC : REP_CYC)
                                                  : ((HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC);
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    logic [1:0]       sync_q, sync_d;
    key_state_e       st_q, st_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rep_q, rep_d;
    logic             lo;

    assign lo = ~sync_q[1];

    // Next-state logic: every state change clears the counter, so it never needs to saturate
    always_comb begin
        sync_d = {sync_q[0], key_n};
        st_d   = st_q;
        cnt_d  = cnt_q + CNT_W'(1);
        rep_d  = rep_q;
        evt    = 1'b0;
        case (st_q)
            KEY_IDLE: begin
                cnt_d = '0;
                st_d  = lo ? KEY_PRESS_DB : KEY_IDLE;
            end
            KEY_PRESS_DB: begin
                if (!lo) begin
                    st_d  = KEY_IDLE;
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    evt   = 1'b1;
                    st_d  = KEY_HELD;
                    cnt_d = '0;
                end
            end
            KEY_HELD: begin
                if (!lo) begin
                    st_d  = KEY_RELEASE_DB;
                    rep_d = 1'b0;
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    evt   = 1'b1;
                    st_d  = KEY_REPEAT;
                    cnt_d = '0;
                end
            end
            KEY_REPEAT: begin
                if (!lo) begin
                    st_d  = KEY_RELEASE_DB;
                    rep_d = 1'b1;
                    cnt_d = '0;
                end else if (cnt_q == REP_LAST) begin
                    evt   = 1'b1;
                    cnt_d = '0;
                end
            end
            KEY_RELEASE_DB: begin
                if (lo) begin
                    st_d  = rep_q ? KEY_REPEAT : KEY_HELD;
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    st_d  = KEY_IDLE;
                    cnt_d = '0;
                end
            end
            default: begin
                st_d  = KEY_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // State registers; synchroniser resets to the released (high) level
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b11;
            st_q   <= KEY_IDLE;
            cnt_q  <= '0;
            rep_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            rep_q  <= rep_d;
        end
    end

endmodule

// File: rtl/dds_word_ctrl.sv
// dds_word_ctrl: turn two push-buttons into stepped DDS frequency and phase control words
module dds_word_ctrl
    import dds_pkg::*;
#(
    parameter int DEB_CYC  = 1_000_000,
    parameter int HOLD_CYC = 25_000_000,
    parameter int REP_CYC  = 5_000_000,
    parameter int FC_MIN   = FC_MIN_DEF,
    parameter int FC_STEP  = FC_STEP_DEF,
    parameter int FC_MAX   = FC_MAX_DEF,
    parameter int PC_STEP  = PC_STEP_DEF
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              key_f,
    input  logic              key_p,
    output logic [WORD_W-1:0] fc_word,
    output logic [WORD_W-1:0] pc_word,
    output logic              word_upd,
    output logic              led0
);

    localparam int SUM_W = WORD_W + 1;

    logic              ev_f, ev_p, ev_any;
    logic [SUM_W-1:0]  fc_sum;
    logic [WORD_W-1:0] fc_q, fc_d, pc_q, pc_d;
    logic              upd_q, upd_d, led_q, led_d;

    key_repeat #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_key_f (
        .sclk  (sclk),
        .rst_n (rst_n),
        .key_n (key_f),
        .evt   (ev_f)
    );

    key_repeat #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC)) u_key_p (
        .sclk  (sclk),
        .rst_n (rst_n),
        .key_n (key_p),
        .evt   (ev_p)
    );

    assign ev_any = ev_f | ev_p;
    assign fc_sum = {1'b0, fc_q} + SUM_W'(FC_STEP);

    // Word arithmetic: frequency wraps to FC_MIN past FC_MAX, phase wraps naturally
    always_comb begin
        fc_d  = ev_f ? ((fc_sum > SUM_W'(FC_MAX)) ? WORD_W'(FC_MIN) : fc_sum[WORD_W-1:0]) : fc_q;
        pc_d  = ev_p ? pc_q + WORD_W'(PC_STEP) : pc_q;
        upd_d = ev_any;
        led_d = led_q ^ ev_any;
    end

    // Output registers
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            fc_q  <= WORD_W'(FC_MIN);
            pc_q  <= '0;
            upd_q <= 1'b0;
            led_q <= 1'b0;
        end else begin
            fc_q  <= fc_d;
            pc_q  <= pc_d;
            upd_q <= upd_d;
            led_q <= led_d;
        end
    end

    assign fc_word  = fc_q;
    assign pc_word  = pc_q;
    assign word_upd = upd_q;
    assign led0     = led_q;

endmodule
